// File: rtl/fp_mul_pkg.sv
// Shared widths, biases and defaults for the bfloat16 x bfloat16 -> single
// precision multiplier and its request arbiter.
package fp_mul_pkg;

    localparam int BF16_W     = 16;
    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;
    localparam int BF16_BIAS  = 127;

    localparam int SP_W       = 32;
    localparam int SP_EXP_W   = 8;
    localparam int SP_MAN_W   = 23;
    localparam int SP_BIAS    = 127;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LATENCY = 2;

endpackage

// File: rtl/fp_multiplier.sv
// Combinational bfloat16 x bfloat16 multiply producing an IEEE single result.
// Truncating mantissa, no special-value handling, exponent wraps modulo 2^8.
module fp_multiplier
    import fp_mul_pkg::*;
#(
    parameter int IN_WIDTH  = BF16_W,
    parameter int OUT_WIDTH = SP_W
) (
    input  logic [IN_WIDTH-1:0]  a,
    input  logic [IN_WIDTH-1:0]  b,
    output logic [OUT_WIDTH-1:0] y
);

    localparam int EW = BF16_EXP_W;
    localparam int MI = IN_WIDTH - 1 - EW;
    localparam int MO = OUT_WIDTH - 1 - SP_EXP_W;
    localparam int PW = 2 * (MI + 1);
    localparam int FW = PW - 1;
    localparam logic [EW-1:0] EXP_ADJ = EW'(2 * BF16_BIAS - SP_BIAS);

    logic [MI:0]   sig_a;
    logic [MI:0]   sig_b;
    logic [PW-1:0] prod;
    logic          norm;
    logic [FW-1:0] frac;
    logic [EW-1:0] exp_y;
    logic [MO-1:0] man_y;

    assign sig_a = {1'b1, a[MI-1:0]};
    assign sig_b = {1'b1, b[MI-1:0]};
    assign prod  = PW'(sig_a) * PW'(sig_b);

    // Product of two [1,2) significands lies in [1,4); top bit selects the shift.
    assign norm  = prod[PW-1];
    assign frac  = norm ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    assign exp_y = a[IN_WIDTH-2 -: EW] + b[IN_WIDTH-2 -: EW]
                 - EXP_ADJ + EW'(norm);

    generate
        if (MO > FW) begin : g_pad
            assign man_y = {frac, {(MO - FW){1'b0}}};
        end else if (MO == FW) begin : g_eq
            assign man_y = frac;
        end else begin : g_trunc
            assign man_y = frac[FW-1 -: MO];
        end
    endgenerate

    assign y = {a[IN_WIDTH-1] ^ b[IN_WIDTH-1], exp_y, man_y};

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter feeding one shared fp_multiplier through a
// LATENCY-deep stallable pipeline with in-order tagged responses.
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int IN_WIDTH  = BF16_W,
    parameter int OUT_WIDTH = SP_W,
    parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic [OUT_WIDTH-1:0]         rsp_y,
    output logic                         busy,
    output logic [15:0]                  issue_count
);

    logic                 stall;
    logic                 found;
    logic                 accept;
    logic [ID_WIDTH-1:0]  ptr;
    logic [ID_WIDTH-1:0]  gidx;
    logic [ID_WIDTH:0]    slot;
    logic [NUM_REQ-1:0]   grant;
    logic [LATENCY-1:0]   v_q;
    logic [ID_WIDTH-1:0]  id_q [LATENCY];
    logic [IN_WIDTH-1:0]  a_q;
    logic [IN_WIDTH-1:0]  b_q;
    logic [OUT_WIDTH-1:0] mul_y;
    logic [OUT_WIDTH-1:0] y_last;

    assign rsp_valid = v_q[LATENCY-1];
    assign stall     = rsp_valid & ~rsp_ready;
    assign busy      = |v_q;

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        grant = '0;
        slot  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = {1'b0, ptr} + (ID_WIDTH + 1)'(k);
            if (slot >= (ID_WIDTH + 1)'(NUM_REQ)) begin
                slot = slot - (ID_WIDTH + 1)'(NUM_REQ);
            end
            if (!found && req_valid[slot[ID_WIDTH-1:0]]) begin
                found = 1'b1;
                gidx  = slot[ID_WIDTH-1:0];
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    assign req_ready = grant & {NUM_REQ{rst_n & ~stall}};
    assign accept    = found & rst_n & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            issue_count <= '0;
            v_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                ptr <= (gidx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                        : gidx + ID_WIDTH'(1);
                issue_count <= issue_count + 16'd1;
            end
            if (!stall) begin
                v_q[0] <= accept;
                for (int i = 1; i < LATENCY; i++) begin
                    v_q[i]  <= v_q[i-1];
                    id_q[i] <= id_q[i-1];
                end
                if (accept) begin
                    a_q     <= req_a[int'(gidx) * IN_WIDTH +: IN_WIDTH];
                    b_q     <= req_b[int'(gidx) * IN_WIDTH +: IN_WIDTH];
                    id_q[0] <= gidx;
                end
            end
        end
    end

    fp_multiplier #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_mul (
        .a (a_q),
        .b (b_q),
        .y (mul_y)
    );

    generate
        if (LATENCY == 1) begin : g_direct
            assign y_last = mul_y;
        end else begin : g_pipe
            logic [OUT_WIDTH-1:0] y_q [LATENCY-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        y_q[i] <= '0;
                    end
                end else if (!stall) begin
                    y_q[0] <= mul_y;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        y_q[i] <= y_q[i-1];
                    end
                end
            end
            assign y_last = y_q[LATENCY-2];
        end
    endgenerate

    // Multiplying zeroed stage registers is not zero, so mask idle output.
    assign rsp_y  = rsp_valid ? y_last : '0;
    assign rsp_id = id_q[LATENCY-1];

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomised bench for fp_mul_arbiter against an in-order queue model,
// plus directed arithmetic, fairness, backpressure, reset and wrap cases.
module tb_fp_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 2;
    localparam int IW      = 16;
    localparam int OW      = 32;
    localparam int IDW     = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*IW-1:0]   req_a;
    logic [NUM_REQ*IW-1:0]   req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [OW-1:0]           rsp_y;
    logic                    busy;
    logic [15:0]             issue_count;

    always #5 clk = ~clk;

    fp_mul_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .LATENCY   (LATENCY),
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .ID_WIDTH  (IDW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_y       (rsp_y),
        .busy        (busy),
        .issue_count (issue_count)
    );

    typedef struct {
        int          id;
        logic [31:0] y;
        int          age;
    } ent_t;

    ent_t        q[$];
    int          mptr = 0;
    logic [15:0] mcnt = '0;
    int          ncmp = 0;
    int          nfail = 0;

    // Value-level product: significands as integers, exponent by addition.
    function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b);
        int          e;
        int          p;
        logic [31:0] frac;
        logic [7:0]  e8;
        p = (128 + int'(a[6:0])) * (128 + int'(b[6:0]));
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p >= 32768) begin
            e    = e + 1;
            frac = 32'(p - 32768) << 8;
        end else begin
            frac = 32'(p - 16384) << 9;
        end
        e8 = e[7:0];
        return {a[15] ^ b[15], e8, frac[22:0]};
    endfunction

    function automatic bit m_front();
        return q.size() > 0 && q[0].age == LATENCY;
    endfunction

    function automatic int m_grant();
        int idx;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (mptr + k) % NUM_REQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic [15:0] rnd_op();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)),
                7'($urandom_range(0, 127))};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit fv;
        bit st;
        int g;
        if (!rst_n) begin
            q.delete();
            mptr = 0;
            mcnt = '0;
        end else begin
            fv = m_front();
            st = fv && !rsp_ready;
            g  = m_grant();
            if (fv && rsp_ready) void'(q.pop_front());
            if (!st) begin
                foreach (q[i]) q[i].age++;
                if (g >= 0) begin
                    q.push_back('{g, ref_mul(req_a[g*IW +: IW],
                                             req_b[g*IW +: IW]), 1});
                    mptr = (g + 1) % NUM_REQ;
                    mcnt = mcnt + 16'd1;
                end
            end
        end
    endtask

    task automatic check_cycle();
        bit fv;
        bit st;
        int g;
        int exp_rdy;
        if (!rst_n) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_y", rsp_y, 0);
            chk("rst_issue_count", issue_count, 0);
        end else begin
            fv = m_front();
            st = fv && !rsp_ready;
            g  = m_grant();
            exp_rdy = (g >= 0 && !st) ? (1 << g) : 0;
            chk("req_ready", req_ready, exp_rdy);
            chk("rsp_valid", rsp_valid, fv);
            if (fv) begin
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_y", rsp_y, q[0].y);
            end
            chk("busy", busy, q.size() != 0);
            chk("issue_count", issue_count, mcnt);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check_cycle();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(int i, logic [15:0] a, logic [15:0] b);
        req_a[i*IW +: IW] = a;
        req_b[i*IW +: IW] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, rnd_op(), rnd_op());
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    logic [31:0] held;

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) cyc();
        chk("reset_issue_count", issue_count, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("pin_1x2", ref_mul(16'h3F80, 16'h4000), 32'h40000000);
        chk("pin_sign", ref_mul(16'h3FC0, 16'hBFC0), 32'hC0100000);
        chk("pin_3x4", ref_mul(16'h4040, 16'h4080), 32'h41400000);
        rst_n = 1'b1;

        req_valid = 4'b0001;
        set_op(0, 16'h3F80, 16'h4000);
        #1 chk("single_ready", req_ready, 4'b0001);
        cyc();
        req_valid = '0;
        cyc();
        #1;
        chk("single_valid", rsp_valid, 1);
        chk("single_y", rsp_y, 32'h40000000);
        chk("single_id", rsp_id, 0);
        repeat (2) cyc();

        req_valid = 4'b0100;
        set_op(2, 16'h3FC0, 16'hBFC0);
        #1 chk("sign_ready", req_ready, 4'b0100);
        cyc();
        req_valid = '0;
        cyc();
        #1;
        chk("sign_valid", rsp_valid, 1);
        chk("sign_y", rsp_y, 32'hC0100000);
        chk("sign_id", rsp_id, 2);
        repeat (2) cyc();

        pulse_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            #1;
            chk("fair_grant", onehot_idx(req_ready), k % NUM_REQ);
            chk("fair_flow", rsp_valid, k >= LATENCY);
            cyc();
        end

        rsp_ready = 1'b0;
        held = '0;
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            #1;
            chk("bp_ready", req_ready, 0);
            chk("bp_valid", rsp_valid, 1);
            if (k == 0) held = rsp_y;
            else chk("bp_hold", rsp_y, held);
            cyc();
        end
        rsp_ready = 1'b1;
        repeat (4) begin
            rand_ops();
            cyc();
        end
        req_valid = '0;
        repeat (6) cyc();

        req_valid = 4'b0011;
        rand_ops();
        repeat (2) cyc();
        req_valid = '0;
        chk("mr_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_issue_count", issue_count, 0);
        chk("mr_req_ready", req_ready, 0);
        cyc();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1 chk("mr_ptr_zero", req_ready, 4'b0001);
        req_valid = 4'b1000;
        set_op(3, 16'h4040, 16'h4080);
        #1 chk("mr_ready3", req_ready, 4'b1000);
        cyc();
        req_valid = '0;
        cyc();
        #1;
        chk("mr_valid", rsp_valid, 1);
        chk("mr_y", rsp_y, 32'h41400000);
        chk("mr_id", rsp_id, 3);
        repeat (2) cyc();

        repeat (3000) begin
            req_valid = 4'($urandom_range(0, 15));
            rand_ops();
            rsp_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) cyc();
        chk("drain_busy", busy, 0);
        chk("drain_valid", rsp_valid, 0);

        pulse_reset();
        req_valid = 4'b0001;
        set_op(0, 16'h3F80, 16'h4000);
        repeat (65537) cyc();
        req_valid = '0;
        #1 chk("wrap_count", issue_count, 16'h0001);
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
